conv_addr_ctrl: RTL

- Parametrised address/sequence controller for the 2D-convolution datapath, between the host load/readout interface and the line memories and N_CONV convolvers.
- Runs three phases: LOAD (host writes a block), PROC (free-running read/write addresses with configurable convolver latency), and READ (host drains each convolver's result block in turn).
- Tracks a per-channel pending-result mask instead of a single end-of-process bit.

---
 rtl/conv_ctrl_pkg.sv | 31 +++
 rtl/conv_addr_ctrl_if.sv | 39 +++
 rtl/conv_lsb_sel.sv | 20 ++
 rtl/conv_addr_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared state encoding, default widths and the lowest-set-bit helper for the
// convolution address controller.
package conv_ctrl_pkg;

    localparam int DEF_NB_ADDRESS   = 10;
    localparam int DEF_NB_IMAGE     = 10;
    localparam int DEF_N_CONV       = 4;
    localparam int DEF_CONV_LATENCY = 6;
    localparam int DEF_NB_SEL       = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PROC = 3'd2,
        ST_DONE = 3'd3,
        ST_READ = 3'd4
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic int lowest_set_index(input logic [31:0] mask);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/conv_addr_ctrl_if.sv
// Host-side bundle of the convolution address controller: block length,
// phase requests, data strobe, and the address/enable/status outputs.
interface conv_addr_ctrl_if #(
    parameter int NB_ADDRESS = 10,
    parameter int NB_IMAGE   = 10,
    parameter int N_CONV     = 4,
    parameter int NB_SEL     = 2
) ();

    logic [NB_IMAGE-1:0]   i_imgLength;
    logic                  i_load;
    logic                  i_SoP;
    logic                  i_valid;

    logic [NB_ADDRESS-1:0] o_writeAdd;
    logic [NB_ADDRESS-1:0] o_readAdd;
    logic                  o_wrEn;
    logic                  o_convValid;
    logic                  o_EoP;
    logic [N_CONV-1:0]     o_pending;
    logic [NB_SEL-1:0]     o_readSel;
    logic                  o_changeBlock;
    logic                  o_busy;

    // Host side: drives requests, observes addresses and status.
    modport master (
        output i_imgLength, i_load, i_SoP, i_valid,
        input  o_writeAdd, o_readAdd, o_wrEn, o_convValid, o_EoP,
        input  o_pending, o_readSel, o_changeBlock, o_busy
    );

    // Controller side.
    modport slave (
        input  i_imgLength, i_load, i_SoP, i_valid,
        output o_writeAdd, o_readAdd, o_wrEn, o_convValid, o_EoP,
        output o_pending, o_readSel, o_changeBlock, o_busy
    );

endinterface

// File: rtl/conv_lsb_sel.sv
// Combinational priority encoder: picks the lowest pending convolver channel
// to drain and flags whether any channel is pending at all.
module conv_lsb_sel
    import conv_ctrl_pkg::*;
#(
    parameter int N_CONV = DEF_N_CONV,
    parameter int NB_SEL = DEF_NB_SEL
) (
    input  logic [N_CONV-1:0] mask,
    output logic [NB_SEL-1:0] sel,
    output logic              any
);

    logic [31:0] mask_wide;

    assign mask_wide = 32'(mask);
    assign sel       = NB_SEL'(lowest_set_index(mask_wide));
    assign any       = |mask;

endmodule

// File: rtl/conv_addr_ctrl.sv
// Address/sequence controller for the 2D-convolution datapath: LOAD, PROC and
// READ phases. Define CONV_STALL_EN to make PROC advance only on i_valid cycles.
module conv_addr_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int NB_ADDRESS   = DEF_NB_ADDRESS,
    parameter int NB_IMAGE     = DEF_NB_IMAGE,
    parameter int N_CONV       = DEF_N_CONV,
    parameter int CONV_LATENCY = DEF_CONV_LATENCY,
    parameter int NB_SEL       = DEF_NB_SEL
) (
    input  logic            i_CLK,
    input  logic            i_reset,
    conv_addr_ctrl_if.slave bus
);

    localparam int                NB_LAT  = $clog2(CONV_LATENCY + 1);
    localparam logic [NB_LAT-1:0] LAT_MAX = NB_LAT'(CONV_LATENCY);

    state_t                state_reg, state_next;
    logic [NB_ADDRESS-1:0] rd_reg, rd_next;
    logic [NB_ADDRESS-1:0] wr_reg, wr_next;
    logic [NB_LAT-1:0]     lat_reg, lat_next;
    logic [N_CONV-1:0]     pending_reg, pending_next;
    logic                  valid_prev_reg;

    logic [N_CONV-1:0]     pending_clr;
    logic [NB_SEL-1:0]     sel;
    logic                  any_pending;
    logic [NB_ADDRESS-1:0] last_addr;
    logic                  valid_edge;
    logic                  proc_step;
    logic                  lat_done;
    logic                  at_last_rd;
    logic                  at_last_wr;
    logic                  block_end;
    logic                  read_end;

    assign last_addr  = NB_ADDRESS'(bus.i_imgLength);
    assign valid_edge = bus.i_valid & ~valid_prev_reg;
    assign lat_done   = (lat_reg == LAT_MAX);
    assign at_last_rd = (rd_reg == last_addr);
    assign at_last_wr = (wr_reg == last_addr);

`ifdef CONV_STALL_EN
    assign proc_step = bus.i_valid;
`else
    assign proc_step = 1'b1;
`endif

    // LOAD and READ blocks both end on the valid edge that hits the last address.
    assign block_end = ((state_reg == ST_LOAD) || (state_reg == ST_READ))
                       && valid_edge && at_last_rd;
    assign read_end  = (state_reg == ST_READ) && valid_edge && at_last_rd;

    conv_lsb_sel #(
        .N_CONV (N_CONV),
        .NB_SEL (NB_SEL)
    ) u_lsb_sel (
        .mask (pending_reg),
        .sel  (sel),
        .any  (any_pending)
    );

    // The channel being drained is cleared only when its READ block completes.
    for (genvar gi = 0; gi < N_CONV; gi++) begin : g_pending_clr
        assign pending_clr[gi] = read_end && (sel == NB_SEL'(gi));
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state_reg      <= ST_IDLE;
            rd_reg         <= '0;
            wr_reg         <= '0;
            lat_reg        <= '0;
            pending_reg    <= '0;
            valid_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rd_reg         <= rd_next;
            wr_reg         <= wr_next;
            lat_reg        <= lat_next;
            pending_reg    <= pending_next;
            valid_prev_reg <= bus.i_valid;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_next      = rd_reg;
        wr_next      = wr_reg;
        lat_next     = lat_reg;
        pending_next = pending_reg & ~pending_clr;

        case (state_reg)
            ST_IDLE: begin
                // Exactly one request may be honoured; conflicts leave IDLE untouched.
                if (bus.i_load && !bus.i_SoP && !any_pending) begin
                    state_next = ST_LOAD;
                    rd_next    = '0;
                end else if (!bus.i_load && bus.i_SoP && !any_pending) begin
                    state_next = ST_PROC;
                    rd_next    = '0;
                    wr_next    = '0;
                    lat_next   = '0;
                end else if (!bus.i_load && !bus.i_SoP && any_pending) begin
                    state_next = ST_READ;
                    rd_next    = '0;
                end
            end

            ST_LOAD, ST_READ: begin
                if (valid_edge) begin
                    if (at_last_rd) begin
                        state_next = ST_IDLE;
                    end else begin
                        rd_next = rd_reg + 1'b1;
                    end
                end
            end

            ST_PROC: begin
                if (proc_step) begin
                    if (!at_last_rd) begin
                        rd_next = rd_reg + 1'b1;
                    end
                    // The delay counter stands in for k-CONV_LATENCY; wr only moves once it saturates.
                    if (!lat_done) begin
                        lat_next = lat_reg + 1'b1;
                    end else if (at_last_wr) begin
                        state_next   = ST_DONE;
                        pending_next = '1;
                    end else begin
                        wr_next = wr_reg + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (!bus.i_SoP) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.o_writeAdd    = '0;
        bus.o_readAdd     = '0;
        bus.o_wrEn        = 1'b0;
        bus.o_convValid   = 1'b0;
        bus.o_changeBlock = block_end;
        bus.o_pending     = pending_reg;
        bus.o_EoP         = any_pending;
        bus.o_readSel     = sel;
        bus.o_busy        = (state_reg != ST_IDLE);

        case (state_reg)
            ST_LOAD, ST_READ: begin
                bus.o_writeAdd = rd_reg;
                bus.o_readAdd  = rd_reg;
            end
            ST_PROC: begin
                bus.o_convValid = proc_step;
                bus.o_wrEn      = proc_step & lat_done;
                bus.o_writeAdd  = wr_reg;
                bus.o_readAdd   = rd_reg;
            end
            default: begin
            end
        endcase
    end

endmodule
